fwd_scoreboard: RTL and testbench

- Parametrised operand-forwarding and register-hazard unit for the 5-stage RISC-V core.
- Replaces the fixed two-operand forwarding muxes and the single "virtual stage 6" register with:
  - a configurable-depth write-back history;
  - NUM_RD read ports;
  - a pending-register scoreboard for multi-cycle (mul/div/CP0) results.
- Sits in the IE stage. It takes producer info from the EX/MEM and MEM/WB registers and supplies forwarded operands plus a hazard request to the stall controller.

---
 rtl/fwd_scoreboard_pkg.sv | 21 ++
 rtl/fwd_scoreboard_if.sv | 44 ++++
 rtl/fwd_scoreboard_port_mux.sv | 56 +++++
 rtl/fwd_scoreboard.sv | 142 ++++++++++++++
 tb/tb_fwd_scoreboard.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// Shared pipeline definitions for the IE-stage forwarding/hazard unit:
// default widths, write-back source encodings and the history-entry layout.
package fwd_scoreboard_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int RADDR_DEF = 5;

    typedef enum logic [1:0] {
        REG_SRC_ALU    = 2'd0,
        REG_SRC_MEM    = 2'd1,
        REG_SRC_PC_IMM = 2'd2,
        REG_SRC_PC4    = 2'd3
    } reg_src_e;

    typedef struct packed {
        logic                 v;
        logic [RADDR_DEF-1:0] rd;
        logic [XLEN_DEF-1:0]  data;
    } hist_entry_t;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Bundle between the IE stage and the forwarding scoreboard; the pipeline
// side is the master, the scoreboard is the slave.
interface fwd_scoreboard_if
    import fwd_scoreboard_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int RADDR  = RADDR_DEF,
    parameter int NUM_RD = 2
);
    logic                    stall;
    logic                    p4_we;
    logic [RADDR-1:0]        p4_rd;
    logic [XLEN-1:0]         p4_data;
    logic                    p4_dvalid;
    logic                    wb_we;
    logic [RADDR-1:0]        wb_rd;
    logic [XLEN-1:0]         wb_data;
    logic [NUM_RD*RADDR-1:0] rs_addr;
    logic [NUM_RD*XLEN-1:0]  rf_data;
    logic [NUM_RD*XLEN-1:0]  fwd_data;
    logic [NUM_RD-1:0]       fwd_hit;
    logic                    hazard;
    logic                    mc_issue;
    logic [RADDR-1:0]        mc_rd;
    logic                    mc_done;
    logic [RADDR-1:0]        mc_done_rd;
    logic [RADDR:0]          pend_cnt;
    logic                    mc_conflict;

    modport master (
        output stall, p4_we, p4_rd, p4_data, p4_dvalid,
        output wb_we, wb_rd, wb_data, rs_addr, rf_data,
        output mc_issue, mc_rd, mc_done, mc_done_rd,
        input  fwd_data, fwd_hit, hazard, pend_cnt, mc_conflict
    );

    modport slave (
        input  stall, p4_we, p4_rd, p4_data, p4_dvalid,
        input  wb_we, wb_rd, wb_data, rs_addr, rf_data,
        input  mc_issue, mc_rd, mc_done, mc_done_rd,
        output fwd_data, fwd_hit, hazard, pend_cnt, mc_conflict
    );

endinterface

// File: rtl/fwd_scoreboard_port_mux.sv
// Priority operand selection for one read port: EX/MEM, MEM/WB, retired
// history (youngest first), then the register file.
module fwd_scoreboard_port_mux
    import fwd_scoreboard_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int RADDR  = RADDR_DEF,
    parameter int HIST_N = 1
) (
    input  logic [RADDR-1:0]             rs,
    input  logic [XLEN-1:0]              rf_word,
    input  logic                         p4_we,
    input  logic [RADDR-1:0]             p4_rd,
    input  logic [XLEN-1:0]              p4_data,
    input  logic                         p4_dvalid,
    input  logic                         wb_we,
    input  logic [RADDR-1:0]             wb_rd,
    input  logic [XLEN-1:0]              wb_data,
    input  logic [HIST_N-1:0]            hist_v,
    input  logic [HIST_N-1:0][RADDR-1:0] hist_rd,
    input  logic [HIST_N-1:0][XLEN-1:0]  hist_data,
    input  logic                         pend_bit,
    output logic [XLEN-1:0]              data,
    output logic                         hit,
    output logic                         hazard
);

    always_comb begin
        data   = rf_word;
        hit    = 1'b0;
        hazard = 1'b0;
        if (rs != '0) begin
            // An EX/MEM address match always wins, even for a load whose
            // data is not ready yet: older copies of rs are stale.
            if (p4_we && (p4_rd == rs)) begin
                hit    = 1'b1;
                data   = p4_data;
                hazard = !p4_dvalid;
            end else if (wb_we && (wb_rd == rs)) begin
                hit  = 1'b1;
                data = wb_data;
            end else begin
                for (int k = HIST_N - 1; k >= 0; k--) begin
                    if (hist_v[k] && (hist_rd[k] == rs)) begin
                        hit  = 1'b1;
                        data = hist_data[k];
                    end
                end
            end
            if (pend_bit) begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// IE-stage operand forwarding with a configurable write-back history and a
// pending-register scoreboard for multi-cycle results.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int RADDR      = RADDR_DEF,
    parameter int NUM_RD     = 2,
    parameter int HIST_DEPTH = 1
) (
    input  logic           clk,
    input  logic           rst,
    fwd_scoreboard_if.slave bus
);

    localparam int HIST_N = (HIST_DEPTH > 0) ? HIST_DEPTH : 1;
    localparam int NREG   = 1 << RADDR;
    localparam logic [RADDR:0] CNT_ONE = {{RADDR{1'b0}}, 1'b1};

    logic [HIST_N-1:0]            hist_v_reg;
    logic [HIST_N-1:0][RADDR-1:0] hist_rd_reg;
    logic [HIST_N-1:0][XLEN-1:0]  hist_data_reg;

    logic [NREG-1:0]  pend_reg;
    logic [NREG-1:0]  pend_next;
    logic [RADDR:0]   cnt_reg;
    logic [RADDR:0]   cnt_next;
    logic             conflict_reg;
    logic             conflict_next;
    logic             issue_ok;
    logic             done_ok;
    logic             same_reg;
    logic             cnt_inc;
    logic             cnt_dec;

    logic [NUM_RD-1:0][XLEN-1:0] port_data;
    logic [NUM_RD-1:0]           port_hit;
    logic [NUM_RD-1:0]           port_haz;

    // Write-back history
    generate
        if (HIST_DEPTH > 0) begin : g_hist
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hist_v_reg    <= '0;
                    hist_rd_reg   <= '0;
                    hist_data_reg <= '0;
                end else if (!bus.stall) begin
                    hist_v_reg[0]    <= bus.wb_we && (bus.wb_rd != '0);
                    hist_rd_reg[0]   <= bus.wb_rd;
                    hist_data_reg[0] <= bus.wb_data;
                    for (int k = 1; k < HIST_DEPTH; k++) begin
                        hist_v_reg[k]    <= hist_v_reg[k-1];
                        hist_rd_reg[k]   <= hist_rd_reg[k-1];
                        hist_data_reg[k] <= hist_data_reg[k-1];
                    end
                end
            end
        end else begin : g_no_hist
            assign hist_v_reg    = '0;
            assign hist_rd_reg   = '0;
            assign hist_data_reg = '0;
        end
    endgenerate

    // Read ports
    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
            logic [RADDR-1:0] rs;
            assign rs = bus.rs_addr[gi*RADDR +: RADDR];

            fwd_scoreboard_port_mux #(
                .XLEN   (XLEN),
                .RADDR  (RADDR),
                .HIST_N (HIST_N)
            ) u_mux (
                .rs        (rs),
                .rf_word   (bus.rf_data[gi*XLEN +: XLEN]),
                .p4_we     (bus.p4_we),
                .p4_rd     (bus.p4_rd),
                .p4_data   (bus.p4_data),
                .p4_dvalid (bus.p4_dvalid),
                .wb_we     (bus.wb_we),
                .wb_rd     (bus.wb_rd),
                .wb_data   (bus.wb_data),
                .hist_v    (hist_v_reg),
                .hist_rd   (hist_rd_reg),
                .hist_data (hist_data_reg),
                .pend_bit  (pend_reg[rs]),
                .data      (port_data[gi]),
                .hit       (port_hit[gi]),
                .hazard    (port_haz[gi])
            );
        end
    endgenerate

    assign bus.fwd_data = port_data;
    assign bus.fwd_hit  = port_hit;
    assign bus.hazard   = |port_haz;

    // Scoreboard next state. A same-cycle retire and re-issue of one register
    // leaves the bit set and the count unchanged.
    always_comb begin
        issue_ok      = bus.mc_issue && (bus.mc_rd != '0);
        done_ok       = bus.mc_done && pend_reg[bus.mc_done_rd];
        same_reg      = (bus.mc_rd == bus.mc_done_rd);
        conflict_next = issue_ok && pend_reg[bus.mc_rd] && !(done_ok && same_reg);

        pend_next = pend_reg;
        if (done_ok) begin
            pend_next[bus.mc_done_rd] = 1'b0;
        end
        if (issue_ok) begin
            pend_next[bus.mc_rd] = 1'b1;
        end

        cnt_inc  = issue_ok && !pend_reg[bus.mc_rd];
        cnt_dec  = done_ok && !(issue_ok && same_reg);
        cnt_next = cnt_reg;
        case ({cnt_inc, cnt_dec})
            2'b10:   cnt_next = cnt_reg + CNT_ONE;
            2'b01:   cnt_next = cnt_reg - CNT_ONE;
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_reg     <= '0;
            cnt_reg      <= '0;
            conflict_reg <= 1'b0;
        end else begin
            pend_reg     <= pend_next;
            cnt_reg      <= cnt_next;
            conflict_reg <= conflict_next;
        end
    end

    assign bus.pend_cnt    = cnt_reg;
    assign bus.mc_conflict = conflict_reg;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed and randomized checks of fwd_scoreboard against a queue-based
// model of write-back history and a per-register pending table.
module tb_fwd_scoreboard;
    import fwd_scoreboard_pkg::*;

    localparam int XLEN       = XLEN_DEF;
    localparam int RADDR      = RADDR_DEF;
    localparam int NUM_RD     = 2;
    localparam int HIST_DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fwd_scoreboard_if #(.XLEN(XLEN), .RADDR(RADDR), .NUM_RD(NUM_RD)) bus ();

    fwd_scoreboard #(
        .XLEN(XLEN), .RADDR(RADDR), .NUM_RD(NUM_RD), .HIST_DEPTH(HIST_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit              v;
        logic [RADDR-1:0] rd;
        logic [XLEN-1:0]  data;
    } wb_rec_t;

    wb_rec_t hist_q[$];
    bit      m_pend[1 << RADDR];
    bit      m_conf;
    int      total = 0;
    int      bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_popcount();
        int c = 0;
        foreach (m_pend[r]) c += int'(m_pend[r]);
        return c;
    endfunction

    task automatic model_reset();
        hist_q.delete();
        foreach (m_pend[r]) m_pend[r] = 1'b0;
        m_conf = 1'b0;
    endtask

    // Applies one rising edge worth of the rules to the model.
    task automatic model_clock();
        wb_rec_t rec;
        if (!bus.stall) begin
            rec.v    = bus.wb_we && (bus.wb_rd != 0);
            rec.rd   = bus.wb_rd;
            rec.data = bus.wb_data;
            hist_q.push_front(rec);
            while (hist_q.size() > HIST_DEPTH) void'(hist_q.pop_back());
        end
        m_conf = bus.mc_issue && (bus.mc_rd != 0) && m_pend[bus.mc_rd]
                 && !(bus.mc_done && (bus.mc_done_rd == bus.mc_rd));
        if (bus.mc_done) m_pend[bus.mc_done_rd] = 1'b0;
        if (bus.mc_issue && (bus.mc_rd != 0)) m_pend[bus.mc_rd] = 1'b1;
    endtask

    task automatic expect_port(input int p, output logic [XLEN-1:0] d,
                               output bit h, output bit ld, output bit pz);
        logic [RADDR-1:0] rs;
        rs = bus.rs_addr[p*RADDR +: RADDR];
        d  = bus.rf_data[p*XLEN +: XLEN];
        h  = 1'b0;
        ld = 1'b0;
        pz = 1'b0;
        if (rs != 0) begin
            pz = m_pend[rs];
            if (bus.p4_we && bus.p4_rd == rs) begin
                h  = 1'b1;
                d  = bus.p4_data;
                ld = !bus.p4_dvalid;
            end else if (bus.wb_we && bus.wb_rd == rs) begin
                h = 1'b1;
                d = bus.wb_data;
            end else begin
                foreach (hist_q[k]) begin
                    if (!h && hist_q[k].v && hist_q[k].rd == rs) begin
                        h = 1'b1;
                        d = hist_q[k].data;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [XLEN-1:0] d;
        bit h, ld, pz, haz;
        haz = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            expect_port(p, d, h, ld, pz);
            haz |= ld | pz;
            if (!ld) begin
                chk($sformatf("%s.data%0d", tag, p), 64'(bus.fwd_data[p*XLEN +: XLEN]), 64'(d));
                chk($sformatf("%s.hit%0d", tag, p), 64'(bus.fwd_hit[p]), 64'(h));
            end
        end
        chk({tag, ".hazard"}, 64'(bus.hazard), 64'(haz));
        chk({tag, ".pend_cnt"}, 64'(bus.pend_cnt), 64'(m_popcount()));
        chk({tag, ".conflict"}, 64'(bus.mc_conflict), 64'(m_conf));
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.stall      = 1'b0;
        bus.p4_we      = 1'b0;
        bus.p4_rd      = '0;
        bus.p4_data    = '0;
        bus.p4_dvalid  = 1'b1;
        bus.wb_we      = 1'b0;
        bus.wb_rd      = '0;
        bus.wb_data    = '0;
        bus.rf_data    = {$urandom, $urandom};
        bus.mc_issue   = 1'b0;
        bus.mc_rd      = '0;
        bus.mc_done    = 1'b0;
        bus.mc_done_rd = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        bus.rs_addr = {5'd9, 5'd5};
        model_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst.fwd_data", 64'(bus.fwd_data), 64'(bus.rf_data));
        chk("rst.fwd_hit", 64'(bus.fwd_hit), 64'(0));
        chk("rst.pend_cnt", 64'(bus.pend_cnt), 64'(0));
        chk("rst.conflict", 64'(bus.mc_conflict), 64'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ALU result forwarded back-to-back
        bus.p4_we = 1'b1; bus.p4_rd = 5'd5; bus.p4_data = 32'h11; bus.p4_dvalid = 1'b1;
        bus.rs_addr = {5'd0, 5'd5};
        #1;
        chk("alu.data0", 64'(bus.fwd_data[31:0]), 64'h11);
        chk("alu.hit0", 64'(bus.fwd_hit[0]), 64'(1));
        chk("alu.hazard", 64'(bus.hazard), 64'(0));
        check_all("alu");
        tick();

        // Load-use then the loaded value arriving from WB
        bus.p4_rd = 5'd7; bus.p4_dvalid = 1'b0; bus.rs_addr = {5'd7, 5'd1};
        #1;
        chk("load.hazard", 64'(bus.hazard), 64'(1));
        check_all("load");
        tick();
        bus.p4_we = 1'b0; bus.wb_we = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'hAB;
        #1;
        chk("load_wb.data1", 64'(bus.fwd_data[63:32]), 64'hAB);
        chk("load_wb.hit1", 64'(bus.fwd_hit[1]), 64'(1));
        chk("load_wb.hazard", 64'(bus.hazard), 64'(0));
        tick();

        // History depth, youngest-first and stall hold
        idle();
        bus.rs_addr = {5'd0, 5'd3};
        bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h100;
        tick();
        bus.wb_data = 32'h200;
        tick();
        bus.wb_we = 1'b0;
        #1;
        chk("hist.young", 64'(bus.fwd_data[31:0]), 64'h200);
        chk("hist.young_hit", 64'(bus.fwd_hit[0]), 64'(1));
        tick();
        #1;
        chk("hist.entry1", 64'(bus.fwd_data[31:0]), 64'h200);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk($sformatf("hist.stall%0d", i), 64'(bus.fwd_data[31:0]), 64'h200);
        end
        bus.stall = 1'b0;
        tick();
        #1;
        chk("hist.aged_hit", 64'(bus.fwd_hit[0]), 64'(0));
        chk("hist.aged_data", 64'(bus.fwd_data[31:0]), 64'(bus.rf_data[31:0]));
        check_all("hist");

        // Register 0 is never forwarded
        bus.p4_we = 1'b1; bus.p4_rd = 5'd0; bus.p4_data = 32'hFFFF; bus.p4_dvalid = 1'b1;
        bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h55;
        bus.rs_addr = {5'd0, 5'd0}; bus.rf_data = '0;
        #1;
        chk("x0.data0", 64'(bus.fwd_data[31:0]), 64'(0));
        chk("x0.hit0", 64'(bus.fwd_hit[0]), 64'(0));
        tick();
        bus.p4_we = 1'b0; bus.wb_we = 1'b0;
        #1;
        chk("x0.hist_hit", 64'(bus.fwd_hit), 64'(0));

        // Pending scoreboard
        idle();
        bus.rs_addr = {5'd0, 5'd9};
        bus.mc_issue = 1'b1; bus.mc_rd = 5'd9;
        tick();
        bus.mc_issue = 1'b0;
        #1;
        chk("sb.cnt1", 64'(bus.pend_cnt), 64'(1));
        chk("sb.hazard", 64'(bus.hazard), 64'(1));
        chk("sb.no_conflict", 64'(bus.mc_conflict), 64'(0));
        bus.mc_issue = 1'b1;
        tick();
        bus.mc_issue = 1'b0;
        #1;
        chk("sb.conflict", 64'(bus.mc_conflict), 64'(1));
        chk("sb.conflict_cnt", 64'(bus.pend_cnt), 64'(1));
        tick();
        #1;
        chk("sb.conflict_pulse", 64'(bus.mc_conflict), 64'(0));
        bus.mc_issue = 1'b1; bus.mc_done = 1'b1; bus.mc_done_rd = 5'd9;
        tick();
        bus.mc_issue = 1'b0; bus.mc_done = 1'b0;
        #1;
        chk("sb.same_cnt", 64'(bus.pend_cnt), 64'(1));
        chk("sb.same_hazard", 64'(bus.hazard), 64'(1));
        chk("sb.same_conflict", 64'(bus.mc_conflict), 64'(0));
        bus.mc_done = 1'b1;
        tick();
        bus.mc_done = 1'b0;
        #1;
        chk("sb.done_cnt", 64'(bus.pend_cnt), 64'(0));
        chk("sb.done_hazard", 64'(bus.hazard), 64'(0));
        bus.mc_done = 1'b1; bus.mc_done_rd = 5'd4;
        bus.mc_issue = 1'b1; bus.mc_rd = 5'd0;
        tick();
        bus.mc_done = 1'b0; bus.mc_issue = 1'b0;
        #1;
        chk("sb.ignored_cnt", 64'(bus.pend_cnt), 64'(0));
        check_all("sb");

        // Randomized traffic on a small register window to force collisions
        for (int n = 0; n < 400; n++) begin
            bus.stall      = ($urandom_range(0, 7) == 0);
            bus.p4_we      = 1'($urandom_range(0, 1));
            bus.p4_rd      = 5'($urandom_range(0, 7));
            bus.p4_data    = $urandom;
            bus.p4_dvalid  = ($urandom_range(0, 3) != 0);
            bus.wb_we      = 1'($urandom_range(0, 1));
            bus.wb_rd      = 5'($urandom_range(0, 7));
            bus.wb_data    = $urandom;
            bus.rs_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            bus.rf_data    = {$urandom, $urandom};
            bus.mc_issue   = ($urandom_range(0, 3) == 0);
            bus.mc_rd      = 5'($urandom_range(0, 7));
            bus.mc_done    = ($urandom_range(0, 3) == 0);
            bus.mc_done_rd = 5'($urandom_range(0, 7));
            #1;
            check_all("rnd");
            tick();
        end

        // Asynchronous reset with pending registers and valid history
        idle();
        for (int r = 10; r < 13; r++) begin
            bus.mc_issue = 1'b1; bus.mc_rd = 5'(r);
            tick();
        end
        bus.mc_issue = 1'b0;
        bus.wb_we = 1'b1; bus.wb_rd = 5'd13; bus.wb_data = 32'h77;
        tick();
        idle();
        bus.rs_addr = {5'd10, 5'd13};
        #1;
        chk("arst.pre_hit0", 64'(bus.fwd_hit[0]), 64'(1));
        chk("arst.pre_data0", 64'(bus.fwd_data[31:0]), 64'h77);
        check_all("arst.pre");
        #1 rst = 1'b1;
        #1;
        chk("arst.pend_cnt", 64'(bus.pend_cnt), 64'(0));
        chk("arst.hit", 64'(bus.fwd_hit), 64'(0));
        chk("arst.hazard", 64'(bus.hazard), 64'(0));
        chk("arst.data0", 64'(bus.fwd_data[31:0]), 64'(bus.rf_data[31:0]));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.mc_done = 1'b1; bus.mc_done_rd = 5'd10;
        tick();
        bus.mc_done = 1'b0;
        #1;
        chk("arst.late_done", 64'(bus.pend_cnt), 64'(0));
        check_all("arst.post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
